// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Groups the requester-side byte streams and the UART transmit FIFO write port
// that the arbiter sits between.
//   req_valid  [N_REQ]     per-requester byte valid
//   req_data   [N_REQ*DW]  flattened bytes, requester k at [k*DW +: DW]
//   req_last   [N_REQ]     per-requester end-of-packet, qualified by valid
//   req_ready  [N_REQ]     per-requester accept, at most one bit high
//   wr_en                  FIFO write strobe
//   wr_data    [DW]        FIFO write data
//   full                   FIFO full
// Modports:
//   master - the environment: drives the requesters and the FIFO full flag
//   slave  - the arbiter: accepts bytes and drives the FIFO write port
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_ready;
  logic                wr_en;
  logic [DW-1:0]       wr_data;
  logic                full;

  modport master (
    output req_valid, req_data, req_last, full,
    input  req_ready, wr_en, wr_data
  );

  modport slave (
    input  req_valid, req_data, req_last, full,
    output req_ready, wr_en, wr_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin, packet-locked arbiter sharing one UART transmit FIFO among
// N_REQ requesters. A grant is held until the granted requester flags the last
// byte of its packet, so messages never interleave on the serial line. A
// requester that stalls mid-packet for TIMEOUT cycles, or that runs for
// MAX_BURST beats without a last marker, is forcibly released and a sticky
// error flag records the event.
// Ports:
//   clk            system clock
//   i_reset        synchronous, active-high reset
//   bus            uart_tx_arbiter_if.slave (requester streams + FIFO write port)
//   o_grant        one-hot current grant, 0 when idle
//   o_busy         high while a grant is held
//   o_err_timeout  sticky, a grant was released by the idle timeout
//   o_err_trunc    sticky, a grant was released by the burst limit
//   i_clr_err      clears both sticky flags
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                i_reset,
  uart_tx_arbiter_if.slave    bus,
  output logic [N_REQ-1:0]    o_grant,
  output logic                o_busy,
  output logic                o_err_timeout,
  output logic                o_err_trunc,
  input  logic                i_clr_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_idx;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   idle_cnt;

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW:0]     cand_sum;

  logic            g_valid;
  logic            g_last;
  logic [DW-1:0]   g_data;

  logic            in_burst;
  logic            beat;
  logic            rel_last;
  logic            rel_trunc;
  logic            rel_tmo;
  logic            release_now;
  logic [IW-1:0]   next_ptr;

  // Round-robin pick: walk the requesters starting at ptr and wrapping. The
  // loop runs from the farthest offset down to offset 0 so the nearest valid
  // requester is the one left standing in sel_idx.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_sum  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand_sum = {1'b0, ptr} + (IW+1)'(i);
      if (cand_sum >= (IW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IW+1)'(N_REQ);
      end
      if (bus.req_valid[cand_sum[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand_sum[IW-1:0];
      end
    end
  end

  // Pull out the granted requester's stream by the stored index.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == IW'(k)) begin
        g_valid = bus.req_valid[k];
        g_last  = bus.req_last[k];
        g_data  = bus.req_data[k*DW +: DW];
      end
    end
  end

  // The data path is combinational from registered state so a byte can move
  // every cycle; o_grant is one-hot and registered, so gating it with ~full
  // gives the per-requester ready directly.
  assign in_burst      = (state == BURST);
  assign beat          = in_burst & g_valid & ~bus.full;
  assign bus.req_ready = (in_burst & ~bus.full) ? o_grant : '0;
  assign bus.wr_en     = beat;
  assign bus.wr_data   = in_burst ? g_data : '0;

  // Release causes. A last beat wins over the burst limit. A timeout needs a
  // cycle with valid low, so it can never coincide with a beat. Backpressure
  // with valid held high does not count toward the timeout.
  assign rel_last    = beat & g_last;
  assign rel_trunc   = beat & ~g_last & (beat_cnt == BW'(MAX_BURST - 1));
  assign rel_tmo     = in_burst & ~g_valid & (idle_cnt == TW'(TIMEOUT - 1));
  assign release_now = rel_last | rel_trunc | rel_tmo;
  assign next_ptr    = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);

  // Arbiter state machine, counters and sticky flags. A set event in the same
  // cycle as i_clr_err leaves the flag set.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt_idx       <= '0;
      o_grant       <= '0;
      o_busy        <= 1'b0;
      beat_cnt      <= '0;
      idle_cnt      <= '0;
      o_err_timeout <= 1'b0;
      o_err_trunc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state    <= BURST;
            gnt_idx  <= sel_idx;
            o_grant  <= N_REQ'(1) << sel_idx;
            o_busy   <= 1'b1;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        BURST: begin
          if (release_now) begin
            state    <= IDLE;
            o_grant  <= '0;
            o_busy   <= 1'b0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            ptr      <= next_ptr;
          end else if (beat) begin
            if (beat_cnt != {BW{1'b1}}) begin
              beat_cnt <= beat_cnt + BW'(1);
            end
            idle_cnt <= '0;
          end else if (!g_valid) begin
            if (idle_cnt != {TW{1'b1}}) begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (rel_trunc) begin
        o_err_trunc <= 1'b1;
      end else if (i_clr_err) begin
        o_err_trunc <= 1'b0;
      end

      if (rel_tmo) begin
        o_err_timeout <= 1'b1;
      end else if (i_clr_err) begin
        o_err_timeout <= 1'b0;
      end
    end
  end

endmodule
